// File: rtl/shift_seq_if.sv
// Request/result bundle for the iterative shifter: operand and shift amount in,
// busy/done/result out.
interface shift_seq_if #(
  parameter int L1 = 8,
  parameter int L2 = 8
);
  logic          start;
  logic [1:0]    op;
  logic [L1-1:0] in1;
  logic [L2-1:0] in2;
  logic          busy;
  logic          done;
  logic [L1-1:0] out;

  modport master (output start, op, in1, in2, input busy, done, out);
  modport slave  (input start, op, in1, in2, output busy, done, out);
endinterface

// File: rtl/shift_seq.sv
// Iterative shifter: one bit position per clock, done pulse when the result
// register updates. Ops: 00 sll, 01 srl, 10 sra, 11 rol.
module shift_seq #(
  parameter int L1 = 8,
  parameter int L2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  shift_seq_if.slave  bus
);
  localparam int CW = $clog2(L1 + 1);
  // Wide enough for both in2 and L1 so clamping never truncates.
  localparam int W  = ((L2 > CW) ? L2 : CW) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [L1-1:0] acc;
  logic [CW-1:0] cnt;
  logic [1:0]    op_r;
  logic [L1-1:0] out_r;
  logic          done_r;

  logic [W-1:0]  in2_w, l1_w, sat, rot;
  logic [CW-1:0] eff;

  always_comb begin
    in2_w = W'(bus.in2);
    l1_w  = W'(L1);
    sat   = (in2_w >= l1_w) ? l1_w : in2_w;
    rot   = in2_w % l1_w;
    eff   = (bus.op == 2'b11) ? CW'(rot) : CW'(sat);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      op_r   <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          acc   <= bus.in1;
          cnt   <= eff;
          op_r  <= bus.op;
          state <= SHIFT;
        end
        SHIFT: if (cnt != '0) begin
          case (op_r)
            2'b00:   acc <= {acc[L1-2:0], 1'b0};
            2'b01:   acc <= {1'b0, acc[L1-1:1]};
            2'b10:   acc <= {acc[L1-1], acc[L1-1:1]};
            default: acc <= {acc[L1-2:0], acc[L1-1]};
          endcase
          cnt <= cnt - 1'b1;
        end else begin
          out_r  <= acc;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = done_r;
  assign bus.out  = out_r;
endmodule

// File: doc/shift_seq.md
# shift_seq

Iterative multi-cycle shifter for the execute stage, used where a full combinational barrel shifter is too large. It accepts an operand and shift amount on a start pulse and shifts one bit position per clock. It supports logical left, logical right, arithmetic right and rotate left. The registered result feeds the execute-stage result mux alongside the combinational arithmetic/shift modules, with a one-cycle `done` pulse.

## Interface
- `L1`, default 8, data width of `in1`/`out` (≥2)
- `L2`, default 8, width of shift amount `in2`
- `clk`  input  1  single clock, rising-edge
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  request; sampled only when idle
- `op`  input  2  00 sll, 01 srl, 10 sra, 11 rol
- `in1`  input  L1  operand
- `in2`  input  L2  shift amount, unsigned
- `busy`  output  1  high while shifting
- `done`  output  1  one-cycle pulse when `out` updates
- `out`  output  L1  result register; holds last result

## Operation
- One clock; reset is asynchronous and active-high.
- States: IDLE, SHIFT. `busy` = (state == SHIFT).
- Internal regs: `acc` (L1), `cnt` (width clog2(L1+1)), `op_r` (2).
- Effective count `eff`:
  - sll/srl/sra: min(in2, L1).
  - rol: in2 mod L1.
  - `in2` wider than `cnt` handled without truncation error, e.g. in2=200, L1=8 → eff=8.
- IDLE & start: acc←in1, cnt←eff, op_r←op, go SHIFT. IDLE & !start: hold.
- SHIFT & cnt≠0: acc shifted one position per op_r; cnt←cnt−1.
  - sll: zero fill at LSB.
  - srl: zero fill at MSB.
  - sra: fill with acc[L1−1].
  - rol: acc[L1−1] → LSB.
- SHIFT & cnt==0: out←acc, done←1, go IDLE.
- `start` while busy: ignored, no queuing; op/operands may change freely.
- `in1`/`in2`/`op` need only be valid in the start cycle.
- Saturation: a shift ≥ L1 gives 0 for sll/srl and all sign bits for sra.
- `done` is high only in the cycle after completion. Otherwise 0.
- Reset mid-operation: aborts immediately to IDLE, no `done`. `out` cleared.

## Timing
- Reset values: state IDLE, busy 0, done 0, out 0, acc 0, cnt 0, op_r 0.
- Start sampled at edge E. `busy` is high from after E through edge E+eff+1.
- `out`/`done` update at edge E+eff+1, so latency is eff+1 cycles.
  - Shift of 0 → 1 cycle.
  - Max L1+1 cycles.
- Back-to-back: in the `done` cycle the FSM is IDLE, so a `start` there is accepted. Sustained throughput is one op per eff+1 cycles.
- `out` changes only on completion or reset. Stable between `done` pulses.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then sll L1=8, in1=8'h81, in2=3 → `done` 4 cycles after start edge, out=8'h08, busy high exactly 4 cycles.
- sra in1=8'h90, in2=2 → out=8'hE4. srl same → 8'h24. rol in1=8'h81, in2=9 → eff 1, out=8'h03, latency 2.
- Saturation: srl in1=8'hFF, in2=200 → out=8'h00 after 9 cycles. sra in1=8'h80, in2=200 → out=8'hFF.
- Zero shift: in1=8'h5A, in2=0, any op → out=8'h5A, `done` 1 cycle after start edge.
- Start pulses while busy (with different operands) are ignored, and the first result is unchanged. A `start` asserted in the `done` cycle is accepted: sll 8'h01 by 1 → 8'h02, 2 cycles later.
- Assert `rst` asynchronously mid-shift (between edges) → busy/done/out read 0 immediately. No `done` afterwards. Next op runs normally.
